// File: rtl/etapa_wb_banco_registros.sv
// Write-back stage and 32-entry register file for the pipeline, with two bypassed
// decode read ports and a valid/ready debug dump of every register.
module etapa_wb_banco_registros #(
  parameter int NBITS  = 32,
  parameter int RNBITS = 5
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NBITS-1:0]  i_PC8,
  input  logic [NBITS-1:0]  i_ALU,
  input  logic [NBITS-1:0]  i_DatoMemoria,
  input  logic [RNBITS-1:0] i_RegistroDestino,
  input  logic [NBITS-1:0]  i_Extension,
  input  logic              i_MemToReg,
  input  logic              i_RegWrite,
  input  logic [1:0]        i_TamanoFiltroL,
  input  logic              i_ZeroExtend,
  input  logic              i_LUI,
  input  logic              i_JAL,
  input  logic [RNBITS-1:0] i_RegLectura1,
  input  logic [RNBITS-1:0] i_RegLectura2,
  output logic [NBITS-1:0]  o_DatoLectura1,
  output logic [NBITS-1:0]  o_DatoLectura2,
  output logic [NBITS-1:0]  o_DatoEscritura,
  input  logic              i_DumpStart,
  input  logic              i_DumpReady,
  output logic              o_DumpValid,
  output logic [RNBITS-1:0] o_DumpIndex,
  output logic [NBITS-1:0]  o_DumpData,
  output logic              o_DumpDone
);

  localparam int NREGS = 2 ** RNBITS;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DUMP,
    ST_DONE
  } dump_state_e;

  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [NBITS-1:0] load_val;
  logic [NBITS-1:0] wb_val;
  logic             we;

  logic [NBITS-1:0] regs_q [NREGS];

  dump_state_e       state_q, state_d;
  logic [RNBITS-1:0] index_q, index_d;

  // Only the low half of the immediate feeds LUI.
  logic unused_ext;
  assign unused_ext = ^i_Extension[NBITS-1:16];

  // Little-endian lane selection for sub-word loads.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and no latch is inferred.
    byte_sel = i_DatoMemoria[7:0];
    case (i_ALU[1:0])
      2'd1:    byte_sel = i_DatoMemoria[15:8];
      2'd2:    byte_sel = i_DatoMemoria[23:16];
      2'd3:    byte_sel = i_DatoMemoria[31:24];
      default: byte_sel = i_DatoMemoria[7:0];
    endcase
    half_sel = i_ALU[1] ? i_DatoMemoria[31:16] : i_DatoMemoria[15:0];

    case (i_TamanoFiltroL)
      2'b00:   load_val = i_ZeroExtend ? {{(NBITS-8){1'b0}}, byte_sel}
                                       : {{(NBITS-8){byte_sel[7]}}, byte_sel};
      2'b01:   load_val = i_ZeroExtend ? {{(NBITS-16){1'b0}}, half_sel}
                                       : {{(NBITS-16){half_sel[15]}}, half_sel};
      default: load_val = i_DatoMemoria;
    endcase

    if (i_JAL)           wb_val = i_PC8;
    else if (i_LUI)      wb_val = {i_Extension[15:0], {(NBITS-16){1'b0}}};
    else if (i_MemToReg) wb_val = load_val;
    else                 wb_val = i_ALU;
  end

  assign o_DatoEscritura = wb_val;
  assign we = i_RegWrite && (i_RegistroDestino != '0);

  always_ff @(posedge i_clk) begin
    // NOTE: the whole file is cleared on reset, so it is built from flops rather than a RAM macro.
    if (i_reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we) begin
      // NOTE: state is updated with non-blocking assignments so every reader sees the pre-edge value.
      regs_q[i_RegistroDestino] <= wb_val;
    end
  end

  // Reads of R0 are hard-wired to zero; a write in flight is forwarded.
  assign o_DatoLectura1 = (i_RegLectura1 == '0) ? '0 :
                          (we && i_RegLectura1 == i_RegistroDestino) ? wb_val : regs_q[i_RegLectura1];
  assign o_DatoLectura2 = (i_RegLectura2 == '0) ? '0 :
                          (we && i_RegLectura2 == i_RegistroDestino) ? wb_val : regs_q[i_RegLectura2];
  assign o_DumpData     = (index_q == '0) ? '0 :
                          (we && index_q == i_RegistroDestino) ? wb_val : regs_q[index_q];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
    end
  end

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    case (state_q)
      ST_IDLE: begin
        index_d = '0;
        if (i_DumpStart) state_d = ST_DUMP;
      end
      ST_DUMP: begin
        if (i_DumpReady) begin
          if (index_q == '1) state_d = ST_DONE;
          else               index_d = index_q + {{(RNBITS-1){1'b0}}, 1'b1};
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        index_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
        index_d = '0;
      end
    endcase
  end

  always_comb begin
    o_DumpValid = (state_q == ST_DUMP);
    o_DumpDone  = (state_q == ST_DONE);
    o_DumpIndex = index_q;
  end

endmodule

// File: tb/tb_etapa_wb_banco_registros.sv
// Directed bench for the write-back stage: reference register-file model plus a
// scoreboard queue of expected results checked as the DUT presents them.
module tb_etapa_wb_banco_registros;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc8, alu, dato_mem, ext;
  logic [4:0]  dest, rd1, rd2;
  logic        mem_to_reg, reg_write, zero_ext, lui, jal;
  logic [1:0]  tam;
  logic [31:0] dl1, dl2, de;
  logic        dump_start, dump_ready, dump_valid, dump_done;
  logic [4:0]  dump_index;
  logic [31:0] dump_data;

  logic [31:0] sb_q[$];
  logic [31:0] rf_m [32];
  logic [31:0] wb_exp;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  etapa_wb_banco_registros dut (
    .i_clk(clk), .i_reset(rst), .i_PC8(pc8), .i_ALU(alu), .i_DatoMemoria(dato_mem),
    .i_RegistroDestino(dest), .i_Extension(ext), .i_MemToReg(mem_to_reg),
    .i_RegWrite(reg_write), .i_TamanoFiltroL(tam), .i_ZeroExtend(zero_ext),
    .i_LUI(lui), .i_JAL(jal), .i_RegLectura1(rd1), .i_RegLectura2(rd2),
    .o_DatoLectura1(dl1), .o_DatoLectura2(dl2), .o_DatoEscritura(de),
    .i_DumpStart(dump_start), .i_DumpReady(dump_ready), .o_DumpValid(dump_valid),
    .o_DumpIndex(dump_index), .o_DumpData(dump_data), .o_DumpDone(dump_done)
  );

  task automatic expect_val(input logic [31:0] v);
    sb_q.push_back(v);
  endtask

  task automatic check_q(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    vectors++;
    if (sb_q.size() == 0) begin
      miscompares++;
      $error("FAIL %s: observed %h, scoreboard empty", tag, obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e) else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] e);
    vectors++;
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, e);
    end
  endtask

  // Advance one edge, mirror the commit in the model, land 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_m[i] = '0;
    end else if (reg_write && dest != 5'd0) begin
      rf_m[dest] = wb_exp;
    end
    #1;
  endtask

  task automatic idle_wb();
    reg_write = 1'b0; mem_to_reg = 1'b0; lui = 1'b0; jal = 1'b0;
    zero_ext = 1'b0; tam = 2'b11; dest = 5'd0; alu = '0; wb_exp = '0;
  endtask

  task automatic wr_alu(input logic [4:0] d, input logic [31:0] v);
    idle_wb();
    reg_write = 1'b1; dest = d; alu = v; wb_exp = v;
  endtask

  task automatic load(input logic [1:0] t, input logic [1:0] ofs, input logic ze,
                      input logic [4:0] d, input logic [31:0] e);
    idle_wb();
    reg_write = 1'b1; mem_to_reg = 1'b1; tam = t; zero_ext = ze;
    alu = {30'h0, ofs}; dest = d; wb_exp = e;
    expect_val(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_idx;
    int cyc;
    logic hs;

    rst = 1'b1; pc8 = '0; dato_mem = 32'h8081_F2A3; ext = '0;
    rd1 = '0; rd2 = '0; dump_start = 1'b0; dump_ready = 1'b0;
    idle_wb();
    for (int i = 0; i < 32; i++) rf_m[i] = 32'hDEAD_BEEF;
    tick(); tick();
    rst = 1'b0;

    // Reset state: every register reads zero, dump FSM idle.
    for (int i = 0; i < 32; i++) begin
      rd1 = 5'(i); rd2 = 5'(31 - i);
      expect_val(32'h0); expect_val(32'h0);
      #1;
      check_q("rst_rd1", dl1);
      check_q("rst_rd2", dl2);
    end
    check_eq("rst_valid", {31'h0, dump_valid}, 32'h0);
    check_eq("rst_done", {31'h0, dump_done}, 32'h0);
    check_eq("rst_index", {27'h0, dump_index}, 32'h0);

    // ALU write with same-cycle bypass, then read back from the file.
    wr_alu(5'd5, 32'h1234_5678); rd1 = 5'd5; rd2 = 5'd6;
    expect_val(32'h1234_5678); expect_val(32'h1234_5678); expect_val(32'h0);
    #1;
    check_q("alu_wb", de);
    check_q("bypass_rd1", dl1);
    check_q("no_bypass_rd2", dl2);
    tick();
    idle_wb(); alu = 32'h0BAD_0BAD; dest = 5'd5; rd2 = 5'd5;
    expect_val(rf_m[5]); expect_val(32'h0BAD_0BAD);
    #1;
    check_q("r5_readback", dl2);
    check_q("wb_valid_no_write", de);

    // Load filter on 0x8081F2A3.
    load(2'b00, 2'd1, 1'b0, 5'd6, 32'hFFFF_FFF2); #1; check_q("lb_ofs1_sx", de); tick();
    load(2'b00, 2'd1, 1'b1, 5'd7, 32'h0000_00F2); #1; check_q("lbu_ofs1", de); tick();
    load(2'b01, 2'd2, 1'b0, 5'd9, 32'hFFFF_8081); #1; check_q("lh_ofs2_sx", de); tick();
    load(2'b00, 2'd3, 1'b1, 5'd10, 32'h0000_0080); #1; check_q("lbu_ofs3", de); tick();
    load(2'b01, 2'd0, 1'b1, 5'd11, 32'h0000_F2A3); #1; check_q("lhu_ofs0", de); tick();
    load(2'b10, 2'd0, 1'b0, 5'd12, 32'h8081_F2A3); #1; check_q("lw_tam10", de); tick();
    load(2'b11, 2'd0, 1'b1, 5'd13, 32'h8081_F2A3); #1; check_q("lw_tam11", de); tick();
    idle_wb(); rd1 = 5'd6; rd2 = 5'd9;
    expect_val(32'hFFFF_FFF2); expect_val(32'hFFFF_8081);
    #1;
    check_q("r6_lb", dl1);
    check_q("r9_lh", dl2);

    // Priority JAL > LUI > MemToReg, and R0 writes dropped.
    idle_wb(); reg_write = 1'b1; jal = 1'b1; lui = 1'b1; mem_to_reg = 1'b1;
    pc8 = 32'h40; ext = 32'h0000_ABCD; dest = 5'd31; wb_exp = 32'h40;
    expect_val(32'h40); #1; check_q("prio_jal", de); tick();
    jal = 1'b0; dest = 5'd8; wb_exp = 32'hABCD_0000;
    expect_val(32'hABCD_0000); #1; check_q("prio_lui", de); tick();
    wr_alu(5'd0, 32'hFFFF_FFFF); rd1 = 5'd0; rd2 = 5'd31;
    expect_val(32'h0); expect_val(32'h40);
    #1;
    check_q("r0_no_bypass", dl1);
    check_q("r31_jal", dl2);
    tick();
    idle_wb(); rd1 = 5'd0; rd2 = 5'd8;
    expect_val(32'h0); expect_val(32'hABCD_0000);
    #1;
    check_q("r0_dropped", dl1);
    check_q("r8_lui", dl2);

    // Populate the remaining registers so the dump has distinct contents.
    for (int i = 14; i < 31; i++) begin
      wr_alu(5'(i), 32'hA500_0000 | 32'(i * 257));
      tick();
    end
    idle_wb();

    // Dump with ready held high: 32 consecutive words, then one done pulse.
    dump_ready = 1'b1; dump_start = 1'b1;
    #1;
    check_eq("start_latency", {31'h0, dump_valid}, 32'h0);
    tick();
    for (int k = 0; k < 32; k++) begin
      expect_val(32'(k)); expect_val(rf_m[k]);
    end
    for (int k = 0; k < 32; k++) begin
      if (k == 20) dump_start = 1'b0;
      #1;
      check_eq("dump_valid", {31'h0, dump_valid}, 32'h1);
      check_q("dump_index", {27'h0, dump_index});
      check_q("dump_data", dump_data);
      tick();
    end
    #1;
    check_eq("dump_done", {31'h0, dump_done}, 32'h1);
    check_eq("done_valid", {31'h0, dump_valid}, 32'h0);
    tick();
    #1;
    check_eq("done_one_cycle", {31'h0, dump_done}, 32'h0);

    // Dump with ready toggling and pipeline writes in flight.
    dump_start = 1'b1; dump_ready = 1'b0;
    tick();
    dump_start = 1'b0;
    exp_idx = 0; cyc = 0;
    while (exp_idx < 32 && cyc < 200) begin
      dump_ready = ((cyc % 3) != 0);
      wr_alu(5'((cyc % 31) + 1), $urandom);
      expect_val(32'(exp_idx));
      expect_val((exp_idx != 0 && dest == 5'(exp_idx)) ? wb_exp : rf_m[exp_idx]);
      #1;
      check_eq("tog_valid", {31'h0, dump_valid}, 32'h1);
      check_q("tog_index", {27'h0, dump_index});
      check_q("tog_data", dump_data);
      hs = dump_ready;
      tick();
      if (hs) exp_idx++;
      cyc++;
    end
    idle_wb(); dump_ready = 1'b0;
    #1;
    check_eq("tog_done", {31'h0, dump_done}, 32'h1);
    tick();

    // Reset in the middle of a dump: back to idle without a done pulse.
    dump_ready = 1'b1; dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    repeat (10) tick();
    #1;
    check_eq("pre_rst_index", {27'h0, dump_index}, 32'd10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_eq("mid_rst_valid", {31'h0, dump_valid}, 32'h0);
    check_eq("mid_rst_index", {27'h0, dump_index}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      check_eq("mid_rst_no_done", {31'h0, dump_done}, 32'h0);
      tick();
    end
    rd1 = 5'd31; rd2 = 5'd5;
    expect_val(rf_m[31]); expect_val(32'h0);
    #1;
    check_q("rst_clears_r31", dl1);
    check_q("rst_clears_r5", dl2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
